ahb3lite_sram_slave: RTL and testbench
======================================

Name: ahb3lite_sram_slave

Overview:
- AHB-lite responder (slave) for the master block: decodes its region from HSEL, accepts single and burst transfers (SINGLE, INCR, INCRx, WRAPx), and serves reads and writes from an internal word-organised memory.
- Inserts a configurable number of wait states and returns a two-cycle ERROR response for illegal accesses.
- Sits on the bus behind the HSEL/HREADY mux, one instance per slave ID.

Parameters:
- SLAVE_ID, 2'b01, value of HSEL that selects this slave.
- MEM_DEPTH, 256, number of 32-bit words; power of two, 16..4096.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted before each OKAY completion; 0..15.

Ports:
- HCLK  in  1  clock, rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  2  slave select from the master (HADDR[31:30]).
- HADDR  in  32  address.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 = byte, 1 = half, 2 = word.
- HBURST  in  3  burst type; informational only.
- HTRANS  in  2  IDLE 00, BUSY 01, NONSEQ 10, SEQ 11.
- HWDATA  in  32  write data, data phase.
- HREADY  in  1  bus-level ready (muxed HREADYOUT).
- HRDATA  out  32  read data.
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset (HRESET=1 at a rising edge): state ST_IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, pending transfer dropped, wait counter=0. A reset mid-data-phase aborts the transfer; no write is performed. Memory contents are not reset.
- Address-phase accept: at a rising edge with HREADY=1, HSEL==SLAVE_ID and HTRANS[1]=1. The block registers HADDR[29:0], HWRITE and HSIZE. IDLE, BUSY or an unselected transfer gives a zero-wait OKAY data phase (ST_IDLE).
- Error check at accept: the access is illegal if any of these hold:
  - HSIZE>2;
  - misaligned: half with HADDR[0]=1, or word with HADDR[1:0]!=0;
  - out of range: HADDR[29:2] >= MEM_DEPTH.
- An illegal access goes to ST_ERR1.
- A legal access goes to ST_DATA with the wait counter loaded with WAIT_STATES.
- FSM states:
  - ST_IDLE: HREADYOUT=1, HRESP=0.
  - ST_DATA: while counter>0, HREADYOUT=0, HRESP=0, decrement the counter. When counter==0, HREADYOUT=1, HRESP=0 (completion cycle).
  - ST_ERR1: HREADYOUT=0, HRESP=1; always go to ST_ERR2.
  - ST_ERR2: HREADYOUT=1, HRESP=1; no memory access.
- Exit from every HREADYOUT=1 cycle: the next state comes from the accept rule above, so back-to-back transfers pipeline. A burst beat completes and the next beat's address is accepted on the same edge.
- Write commit: at the edge ending the ST_DATA completion cycle, HWDATA lanes are written to mem[addr_q[IDX+1:2]], little-endian:
  - byte: lane addr_q[1:0];
  - half: lanes {addr_q[1],0} and {addr_q[1],1};
  - word: all lanes.
  Other lanes are unchanged.
- Read data:
  - During the ST_DATA completion cycle of a read, HRDATA = full word mem[addr_q index]; byte and half reads return the whole word.
  - In all other cycles HRDATA=0.
  - A write followed directly by a read of the same word returns the new data.
- Latency: with WAIT_STATES=0, a transfer completes one cycle after its address phase. Each wait state adds one cycle.
- HBURST is not checked. WRAP boundary and INCR address generation are the master's responsibility.
- The block never drives HRESP=1 with HREADYOUT=1 except in ST_ERR2.
- HREADY=0 in ST_IDLE, meaning another slave is stalling: no accept, state holds.

Test Plan:
- Word write, then read-back: SLAVE_ID=01, write NONSEQ word 0xDEADBEEF to 0x4000_0010, then read the same address → OKAY, zero wait, HRDATA=0xDEADBEEF in the read's data phase.
- Byte write: write byte 0x4000_0011 with HWDATA=0x0000AB00 over the prior 0xDEADBEEF → read returns 0xDEADABEF.
- Wait states: WAIT_STATES=2, word read → HREADYOUT=0 for exactly 2 cycles, then 1 with valid HRDATA; HRESP=0 throughout.
- Errors:
  - half write to 0x4000_0013 → ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); memory word unchanged.
  - word at 0x4000_0400 with MEM_DEPTH=256 → same two-cycle ERROR.
- INCR4 burst write: words 1, 2, 3, 4 to 0x4000_0020..2C, back-to-back, WAIT_STATES=0 → 4 completions in 5 cycles; INCR4 read-back returns 1, 2, 3, 4. HSEL=10 traffic is ignored with zero-wait OKAY.
- Reset mid-operation: HRESET=1 during the ST_DATA wait of a write to 0x4000_0030 → next cycle HREADYOUT=1, HRESP=0, HRDATA=0; a later read shows the old contents.

Source files
------------

// File: rtl/ahb3lite_sram_slave.sv
// AHB-lite SRAM responder: word-organised memory with byte lanes,
// programmable wait states and a two-cycle ERROR response for illegal accesses.
module ahb3lite_sram_slave #(
    parameter logic [1:0] SLAVE_ID    = 2'b01,
    parameter int         MEM_DEPTH   = 256,
    parameter int         WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [1:0]  HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int         IDX         = $clog2(MEM_DEPTH);
    localparam logic [27:0] DEPTH_WORDS = 28'(MEM_DEPTH);
    localparam logic [3:0]  WAIT_INIT   = 4'(WAIT_STATES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;

    logic [1:0]     state;
    logic [3:0]     wait_cnt;
    logic [IDX+1:0] addr_p1;
    logic           write_p1;
    logic [1:0]     size_p1;
    logic [3:0]     lane_en;
    logic [31:0]    mem [MEM_DEPTH];

    logic accept;
    logic illegal;
    logic done;
    logic wr_commit;
    logic unused_bits;

    function automatic logic access_illegal(input logic [2:0] size, input logic [29:0] addr);
        logic bad;
        bad = (size > 3'd2);
        if (size == 3'd1 && addr[0])
            bad = 1'b1;
        if (size == 3'd2 && addr[1:0] != 2'b00)
            bad = 1'b1;
        if (addr[29:2] >= DEPTH_WORDS)
            bad = 1'b1;
        return bad;
    endfunction

    assign accept      = HREADY && (HSEL == SLAVE_ID) && HTRANS[1];
    assign illegal     = access_illegal(HSIZE, HADDR[29:0]);
    assign done        = (state == ST_DATA) && (wait_cnt == 4'd0);
    assign wr_commit   = done && write_p1 && !HRESET;
    assign unused_bits = ^{HADDR[31:30], HBURST, HTRANS[0]};

    assign HREADYOUT = (state == ST_ERR1) ? 1'b0 :
                       (state == ST_DATA) ? (wait_cnt == 4'd0) : 1'b1;
    assign HRESP     = (state == ST_ERR1) || (state == ST_ERR2);
    assign HRDATA    = (done && !write_p1) ? mem[addr_p1[IDX+1:2]] : 32'h0;

    // Control: every cycle with HREADYOUT=1 re-evaluates the accept rule
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
        end else if (state == ST_ERR1) begin
            state <= ST_ERR2;
        end else if (state == ST_DATA && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end else if (accept) begin
            if (illegal) begin
                state <= ST_ERR1;
            end else begin
                state    <= ST_DATA;
                wait_cnt <= WAIT_INIT;
            end
        end else begin
            state <= ST_IDLE;
        end
    end

    // Address phase -> data phase
    always_ff @(posedge HCLK) begin
        if (HREADYOUT && accept) begin
            addr_p1  <= HADDR[IDX+1:0];
            write_p1 <= HWRITE;
            size_p1  <= HSIZE[1:0];
        end
    end

    always_comb begin
        lane_en = 4'b0000;
        case (size_p1)
            2'd0:    lane_en[addr_p1[1:0]] = 1'b1;
            2'd1:    lane_en = addr_p1[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    // Write commit at the edge closing the completion cycle
    always_ff @(posedge HCLK) begin
        if (wr_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b])
                    mem[addr_p1[IDX+1:2]][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Two-slave AHB-lite bench: slave 01 (no wait states) and slave 10 (two wait
// states) behind an HREADY mux, driven by a pipelined master and a memory model.
module tb_ahb3lite_sram_slave;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [1:0]  HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] rdata_a, rdata_b;
    logic        rdy_a, rdy_b, resp_a, resp_b;
    logic [1:0]  dp_sel;

    always #5 HCLK = ~HCLK;

    assign HREADY = (dp_sel == 2'b01) ? rdy_a : (dp_sel == 2'b10) ? rdy_b : 1'b1;

    ahb3lite_sram_slave #(.SLAVE_ID(2'b01), .MEM_DEPTH(256), .WAIT_STATES(0)) dut_a (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRDATA(rdata_a), .HREADYOUT(rdy_a), .HRESP(resp_a)
    );

    ahb3lite_sram_slave #(.SLAVE_ID(2'b10), .MEM_DEPTH(256), .WAIT_STATES(2)) dut_b (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRDATA(rdata_b), .HREADYOUT(rdy_b), .HRESP(resp_b)
    );

    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [1:0]  trans;
    } xfer_t;

    xfer_t       q[$];
    logic [31:0] ref_a [256];
    logic [31:0] ref_b [256];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          seq_cycles;
    logic [31:0] last_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit targets(input xfer_t t);
        return t.trans[1] && (t.sel == 2'b01 || t.sel == 2'b10);
    endfunction

    function automatic int offset_of(input xfer_t t);
        return int'(t.addr[29:0]);
    endfunction

    function automatic bit is_legal(input xfer_t t);
        int off;
        off = offset_of(t);
        if (t.size > 3'd2) return 1'b0;
        if (off % (1 << t.size) != 0) return 1'b0;
        if (off / 4 >= 256) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int wait_of(input logic [1:0] sel);
        return (sel == 2'b01) ? 0 : 2;
    endfunction

    function automatic logic [31:0] read_ref(input logic [1:0] sel, input int idx);
        return (sel == 2'b01) ? ref_a[idx] : ref_b[idx];
    endfunction

    task automatic write_ref(input xfer_t t);
        int off, lo, n;
        logic [31:0] w;
        off = offset_of(t);
        lo  = off % 4;
        n   = 1 << t.size;
        w   = read_ref(t.sel, off / 4);
        for (int b = 0; b < 4; b++)
            if (b >= lo && b < lo + n) w[8*b +: 8] = t.wdata[8*b +: 8];
        if (t.sel == 2'b01) ref_a[off / 4] = w;
        else                ref_b[off / 4] = w;
    endtask

    task automatic push(input logic [1:0] sel, input int off, input bit wr,
                        input int size, input logic [31:0] wd, input logic [1:0] tr);
        xfer_t t;
        t.sel   = sel;
        t.addr  = {sel, 30'(off)};
        t.wr    = wr;
        t.size  = 3'(size);
        t.wdata = wd;
        t.trans = tr;
        q.push_back(t);
    endtask

    // Pipelined master: one address phase and one data phase in flight
    task automatic run_seq();
        xfer_t ap, dp;
        bit ap_v, dp_v, rdy, on_a, on_b;
        int k;
        logic [31:0] er;
        logic e_rdy, e_resp;
        ap = '0; dp = '0; ap_v = 1'b0; dp_v = 1'b0; k = 0;
        seq_cycles = 0;
        if (q.size() > 0) begin ap = q.pop_front(); ap_v = 1'b1; end
        while (ap_v || dp_v) begin
            if (ap_v) begin
                HSEL = ap.sel; HADDR = ap.addr; HWRITE = ap.wr;
                HSIZE = ap.size; HTRANS = ap.trans; HBURST = 3'd1;
            end else begin
                HSEL = 2'b00; HADDR = $urandom; HWRITE = 1'b0;
                HSIZE = 3'd2; HTRANS = 2'b00; HBURST = 3'd0;
            end
            HWDATA = dp_v ? dp.wdata : $urandom;
            @(negedge HCLK);
            seq_cycles++;
            e_rdy = 1'b1; e_resp = 1'b0; er = 32'h0;
            if (dp_v && targets(dp)) begin
                if (!is_legal(dp)) begin
                    e_rdy  = (k >= 1);
                    e_resp = 1'b1;
                end else if (k < wait_of(dp.sel)) begin
                    e_rdy = 1'b0;
                end else if (!dp.wr) begin
                    er = read_ref(dp.sel, offset_of(dp) / 4);
                end
            end
            on_a = dp_v && targets(dp) && dp.sel == 2'b01;
            on_b = dp_v && targets(dp) && dp.sel == 2'b10;
            chk("rdy_a",  32'(rdy_a),  on_a ? 32'(e_rdy)  : 32'd1);
            chk("resp_a", 32'(resp_a), on_a ? 32'(e_resp) : 32'd0);
            chk("rdata_a", rdata_a,    on_a ? er : 32'h0);
            chk("rdy_b",  32'(rdy_b),  on_b ? 32'(e_rdy)  : 32'd1);
            chk("resp_b", 32'(resp_b), on_b ? 32'(e_resp) : 32'd0);
            chk("rdata_b", rdata_b,    on_b ? er : 32'h0);
            rdy = HREADY;
            if (rdy && dp_v && targets(dp) && is_legal(dp) && !dp.wr)
                last_rd = on_a ? rdata_a : rdata_b;
            @(posedge HCLK); #1;
            if (rdy) begin
                if (dp_v && targets(dp) && is_legal(dp) && dp.wr) write_ref(dp);
                dp = ap; dp_v = ap_v; k = 0;
                dp_sel = (ap_v && targets(ap)) ? ap.sel : 2'b00;
                if (q.size() > 0) begin ap = q.pop_front(); ap_v = 1'b1; end
                else ap_v = 1'b0;
            end else begin
                k++;
            end
            if (seq_cycles > 20000) begin
                chk("seq_timeout", 32'(seq_cycles), 32'd20000);
                q.delete();
                break;
            end
        end
        HSEL = 2'b00; HTRANS = 2'b00; dp_sel = 2'b00;
    endtask

    initial begin
        HRESET = 1'b1; HSEL = 2'b00; HADDR = '0; HWRITE = 1'b0; HSIZE = 3'd2;
        HBURST = 3'd0; HTRANS = 2'b00; HWDATA = '0; dp_sel = 2'b00; last_rd = '0;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_rdy_a", 32'(rdy_a), 32'd1);
        chk("rst_resp_a", 32'(resp_a), 32'd0);
        chk("rst_rdata_a", rdata_a, 32'h0);
        chk("rst_rdy_b", 32'(rdy_b), 32'd1);
        chk("rst_resp_b", 32'(resp_b), 32'd0);
        chk("rst_rdata_b", rdata_b, 32'h0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;

        // Known contents everywhere so every read has a defined expectation
        for (int i = 0; i < 256; i++) push(2'b01, i * 4, 1'b1, 2, $urandom, (i % 4 == 0) ? 2'b10 : 2'b11);
        for (int i = 0; i < 256; i++) push(2'b10, i * 4, 1'b1, 2, $urandom, (i % 4 == 0) ? 2'b10 : 2'b11);
        run_seq();

        push(2'b01, 'h10, 1'b1, 2, 32'hDEADBEEF, 2'b10);
        push(2'b01, 'h10, 1'b0, 2, 32'h0, 2'b10);
        run_seq();
        chk("word_readback", last_rd, 32'hDEADBEEF);

        push(2'b01, 'h11, 1'b1, 0, 32'h0000AB00, 2'b10);
        push(2'b01, 'h10, 1'b0, 2, 32'h0, 2'b10);
        run_seq();
        chk("byte_merge", last_rd, 32'hDEADABEF);

        push(2'b10, 'h40, 1'b1, 2, 32'hCAFEF00D, 2'b10);
        push(2'b10, 'h40, 1'b0, 2, 32'h0, 2'b10);
        run_seq();
        chk("wait_readback", last_rd, 32'hCAFEF00D);

        push(2'b01, 'h13, 1'b1, 1, 32'h55555555, 2'b10);
        push(2'b01, 'h400, 1'b0, 2, 32'h0, 2'b10);
        push(2'b01, 'h10, 1'b0, 2, 32'h0, 2'b10);
        run_seq();
        chk("err_unchanged", last_rd, 32'hDEADABEF);

        for (int i = 0; i < 4; i++) push(2'b01, 'h20 + 4 * i, 1'b1, 2, 32'(i + 1), (i == 0) ? 2'b10 : 2'b11);
        run_seq();
        chk("incr4_cycles", 32'(seq_cycles), 32'd5);
        for (int i = 0; i < 4; i++) push(2'b01, 'h20 + 4 * i, 1'b0, 2, 32'h0, (i == 0) ? 2'b10 : 2'b11);
        push(2'b10, 'h24, 1'b0, 2, 32'h0, 2'b10);
        push(2'b11, 'h24, 1'b0, 2, 32'h0, 2'b10);
        push(2'b01, 'h2C, 1'b0, 2, 32'h0, 2'b10);
        run_seq();
        chk("incr4_last", last_rd, 32'd4);

        for (int i = 0; i < 400; i++) begin
            int r, word, boff, size;
            logic [1:0] sel, tr;
            bit wr;
            r    = $urandom_range(0, 9);
            sel  = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
            r    = $urandom_range(0, 9);
            tr   = (r < 6) ? 2'b10 : (r < 8) ? 2'b11 : (r == 8) ? 2'b00 : 2'b01;
            size = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            word = $urandom_range(0, 255);
            if ($urandom_range(0, 15) == 0) word = $urandom_range(256, 2000);
            boff = $urandom_range(0, 3);
            if (size <= 2 && $urandom_range(0, 7) != 0) boff = boff & ~((1 << size) - 1);
            wr   = 1'($urandom_range(0, 1));
            push(sel, word * 4 + boff, wr, size, $urandom, tr);
            if (wr && $urandom_range(0, 2) == 0) push(sel, word * 4, 1'b0, 2, 32'h0, 2'b10);
        end
        run_seq();

        // Reset during the wait phase of a slave-10 write
        HSEL = 2'b10; HADDR = 32'h8000_0030; HWRITE = 1'b1; HSIZE = 3'd2; HTRANS = 2'b10;
        @(posedge HCLK); #1;
        dp_sel = 2'b10; HSEL = 2'b00; HTRANS = 2'b00; HWDATA = 32'h1234_5678;
        @(negedge HCLK);
        chk("mid_wait_rdy_b", 32'(rdy_b), 32'd0);
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        HRESET = 1'b0; dp_sel = 2'b00;
        @(negedge HCLK);
        chk("mid_rst_rdy_b", 32'(rdy_b), 32'd1);
        chk("mid_rst_resp_b", 32'(resp_b), 32'd0);
        chk("mid_rst_rdata_b", rdata_b, 32'h0);
        @(posedge HCLK); #1;
        push(2'b10, 'h30, 1'b0, 2, 32'h0, 2'b10);
        run_seq();
        chk("mid_rst_no_write", last_rd, ref_b[12]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
